led_pixel_engine: RTL and testbench

Parametrised per-pixel colour engine for the WS2811 LED chain, producing CHANNELS colour bytes per LED (RGB, RGBW, …). It sits between the strip output sequencer, which requests pixels by LED index, and the animation clock and user control registers. It replaces the fixed 32-phase schedule with a valid/ready request/response handshake and a single shared 8×8 multiplier. The rainbow lookup ROM is replaced by computed triangle waves, and an inverse-chase animation mode is added.

---
 rtl/led_pixel_engine.sv | 196 +++++++++++++++++++
 tb/tb_led_pixel_engine.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/led_pixel_engine.sv
// Per-pixel colour engine for a WS2811 chain: valid/ready pixel requests, one
// shared 8x8 multiplier sequenced over a per-channel MA/MB/AN/FD loop.
module led_pixel_engine #(
  parameter int CHANNELS = 3,
  parameter int NUMLEDS  = 50
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [7:0]            req_index,
  input  logic [1:0]            mode,
  input  logic [2:0]            colmode,
  input  logic [7:0]            blocksize,
  input  logic [8*CHANNELS-1:0] usera,
  input  logic [8*CHANNELS-1:0] userb,
  input  logic [7:0]            masterfader,
  input  logic [7:0]            animationcounter,
  input  logic [7:0]            stepclock,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [8*CHANNELS-1:0] pix_data
);

  localparam logic [15:0] SPAN = 16'(NUMLEDS + 5);

  typedef enum logic [3:0] {
    S_IDLE, S_PREP, S_PROX, S_LEVEL, S_MA, S_MB, S_AN, S_FD, S_OUT
  } state_t;

  typedef struct packed {
    logic [7:0]            idx;
    logic [1:0]            mode;
    logic [2:0]            colmode;
    logic [7:0]            blk;
    logic [8*CHANNELS-1:0] a;
    logic [8*CHANNELS-1:0] b;
    logic [7:0]            fader;
    logic [7:0]            actr;
    logic [7:0]            step;
  } req_t;

  state_t      state, nxt;
  req_t        cfg;
  logic [1:0]  ch;
  logic [7:0]  norm, prox, col, anim;
  logic [15:0] fracpos, proxa, acc;

  logic [7:0]  mul_a, mul_b;
  logic [15:0] mul_p;
  logic [7:0]  a_c, b_c, col_nxt, anim_nxt, rb_x;
  logic [1:0]  pal;
  logic        last_ch, moving;
  logic [15:0] ipos;

  assign mul_p   = 16'(mul_a) * 16'(mul_b);
  assign last_ch = (ch == 2'(CHANNELS - 1));
  assign moving  = (cfg.colmode == 3'd3) || (cfg.colmode == 3'd6);
  assign ipos    = {cfg.idx, 8'h00};
  assign pal     = cfg.step[1:0] + cfg.idx[1:0];
  assign rb_x    = norm + 8'(85 * int'(ch));

  always_comb begin
    a_c = '0;
    b_c = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch == 2'(i)) begin
        a_c = cfg.a[8*i +: 8];
        b_c = cfg.b[8*i +: 8];
      end
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  // next state
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (req_valid) nxt = S_PREP;
      S_PREP:  nxt = S_PROX;
      S_PROX:  nxt = S_LEVEL;
      S_LEVEL: nxt = S_MA;
      S_MA:    nxt = S_MB;
      S_MB:    nxt = S_AN;
      S_AN:    nxt = S_FD;
      S_FD:    nxt = last_ch ? S_OUT : S_MA;
      S_OUT:   if (pix_ready) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // outputs: handshake and the single multiplier's operand steering
  always_comb begin
    req_ready = (state == S_IDLE);
    mul_a     = '0;
    mul_b     = '0;
    case (state)
      S_PREP: begin mul_a = cfg.idx; mul_b = cfg.blk;  end
      S_MA:   begin mul_a = a_c;     mul_b = norm;     end
      S_MB:   begin mul_a = b_c;     mul_b = ~norm;    end
      S_AN:   begin mul_a = col;     mul_b = (cfg.mode == 2'd2) ? ~prox : prox; end
      S_FD:   begin mul_a = anim;    mul_b = cfg.fader; end
      default: ;
    endcase
  end

  always_comb begin
    col_nxt = '0;
    case (cfg.colmode)
      3'd0:       col_nxt = a_c;
      3'd1:       col_nxt = b_c;
      3'd2, 3'd3: col_nxt = 8'((acc + mul_p) >> 8);
      3'd4: begin
        case (ch)
          2'd0:    col_nxt = (pal == 2'd0 || pal == 2'd3) ? 8'hFF : 8'h00;
          2'd1:    col_nxt = (pal == 2'd1 || pal == 2'd3) ? 8'hFF : 8'h00;
          2'd2:    col_nxt = (pal == 2'd2) ? 8'hFF : 8'h00;
          default: col_nxt = 8'h00;
        endcase
      end
      // triangle wave: 2x on the rising half, 2*(255-x) = 2*~x on the falling half
      3'd5, 3'd6: begin
        if (ch != 2'd3) col_nxt = rb_x[7] ? {~rb_x[6:0], 1'b0} : {rb_x[6:0], 1'b0};
      end
      default:    col_nxt = '0;
    endcase
  end

  always_comb begin
    anim_nxt = '0;
    case (cfg.mode)
      2'd0:       anim_nxt = col;
      2'd1, 2'd2: anim_nxt = mul_p[15:8];
      default:    anim_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg       <= '0;
      ch        <= '0;
      norm      <= '0;
      fracpos   <= '0;
      proxa     <= '0;
      prox      <= '0;
      acc       <= '0;
      col       <= '0;
      anim      <= '0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          cfg.idx     <= req_index;
          cfg.mode    <= mode;
          cfg.colmode <= colmode;
          cfg.blk     <= blocksize;
          cfg.a       <= usera;
          cfg.b       <= userb;
          cfg.fader   <= masterfader;
          cfg.actr    <= animationcounter;
          cfg.step    <= stepclock;
        end
        S_PREP: begin
          norm    <= mul_p[7:0] + (moving ? cfg.actr : cfg.idx);
          // constant-coefficient product; the shared multiplier is busy with idx*blocksize
          fracpos <= 16'(16'(cfg.actr) * SPAN);
        end
        S_PROX:  proxa <= (fracpos >= ipos) ? fracpos - ipos : ipos - fracpos;
        S_LEVEL: begin
          ch <= '0;
          if (proxa >= 16'd1024)   prox <= 8'h00;
          else if (proxa <= 16'd8) prox <= 8'hFF;
          else                     prox <= 8'(16'd256 - {2'b00, proxa[15:2]});
        end
        S_MA: acc  <= mul_p;
        S_MB: col  <= col_nxt;
        S_AN: anim <= anim_nxt;
        S_FD: begin
          for (int i = 0; i < CHANNELS; i++)
            if (ch == 2'(i)) pix_data[8*i +: 8] <= mul_p[15:8];
          if (last_ch) pix_valid <= 1'b1;
          else         ch        <= ch + 2'd1;
        end
        S_OUT: if (pix_ready) pix_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_led_pixel_engine.sv
// Scoreboard bench for led_pixel_engine: directed spec cases plus randomized
// requests checked against an arithmetic reference model.
module tb_led_pixel_engine;
  localparam int CH = 3;
  localparam int NL = 50;
  localparam int DW = 8 * CH;

  logic          clk = 0, rst_n = 0;
  logic          req_valid = 0, req_ready;
  logic [7:0]    req_index = 0;
  logic [1:0]    mode = 0;
  logic [2:0]    colmode = 0;
  logic [7:0]    blocksize = 0, masterfader = 0, animationcounter = 0, stepclock = 0;
  logic [DW-1:0] usera = 0, userb = 0;
  logic          pix_valid, pix_ready;
  logic [DW-1:0] pix_data;

  led_pixel_engine #(.CHANNELS(CH), .NUMLEDS(NL)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_index(req_index), .mode(mode), .colmode(colmode), .blocksize(blocksize),
    .usera(usera), .userb(userb), .masterfader(masterfader),
    .animationcounter(animationcounter), .stepclock(stepclock),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            acc;
    string         nm;
  } exp_t;

  exp_t q[$];
  int   cyc = 0, total = 0, passed = 0;
  bit   seen = 0, force_low = 0, rand_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    if (force_low)       pix_ready = 1'b0;
    else if (rand_ready) pix_ready = ($urandom_range(0, 3) != 0);
    else                 pix_ready = 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [DW-1:0] model(input int idx, md, cm, blk,
                                          input logic [DW-1:0] a, b,
                                          input int fader, actr, step);
    int norm, frac, pa, prox, col, an, s, x, ac, bc;
    logic [DW-1:0] r;
    r    = '0;
    norm = (cm == 3 || cm == 6) ? (idx * blk + actr) % 256 : (idx * blk + idx) % 256;
    frac = (actr * (NL + 5)) % 65536;
    pa   = frac - idx * 256;
    if (pa < 0) pa = -pa;
    prox = (pa >= 1024) ? 0 : (pa <= 8) ? 255 : 256 - pa / 4;
    s    = (step + idx) % 4;
    for (int c = 0; c < CH; c++) begin
      ac = int'(a[8*c +: 8]);
      bc = int'(b[8*c +: 8]);
      case (cm)
        0: col = ac;
        1: col = bc;
        2, 3: col = (ac * norm + bc * (255 - norm)) / 256;
        4: col = ((c == 0 && (s == 0 || s == 3)) || (c == 1 && (s == 1 || s == 3)) ||
                  (c == 2 && s == 2)) ? 255 : 0;
        5, 6: begin
          x   = (norm + 85 * c) % 256;
          col = (c >= 3) ? 0 : (x < 128) ? 2 * x : 2 * (255 - x);
        end
        default: col = 0;
      endcase
      case (md)
        0: an = col;
        1: an = col * prox / 256;
        2: an = col * (255 - prox) / 256;
        default: an = 0;
      endcase
      r[8*c +: 8] = 8'(an * fader / 256);
    end
    return r;
  endfunction

  // Monitor: latency on first valid, stability while stalled, data on handshake.
  always @(negedge clk) begin
    if (!rst_n) seen = 0;
    else if (pix_valid) begin
      if (q.size() == 0) chk("spurious_pix_valid", 32'(pix_valid), 32'd0);
      else begin
        if (!seen) begin
          chk({q[0].nm, "_latency"}, 32'(cyc - q[0].acc), 32'(3 + 4 * CH));
          seen = 1;
        end
        if (pix_ready) begin
          chk({q[0].nm, "_data"}, 32'(pix_data), 32'(q[0].data));
          void'(q.pop_front());
          seen = 0;
        end else chk({q[0].nm, "_hold"}, 32'(pix_data), 32'(q[0].data));
      end
    end
  end

  task automatic send(input int idx, md, cm, blk, input logic [DW-1:0] a, b,
                      input int fader, actr, step, input string nm,
                      input bit use_exp, input logic [DW-1:0] exp);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (!req_ready) begin chk("req_ready_timeout", 32'(req_ready), 32'd1); return; end
    req_index = 8'(idx); mode = 2'(md); colmode = 3'(cm); blocksize = 8'(blk);
    usera = a; userb = b; masterfader = 8'(fader); animationcounter = 8'(actr);
    stepclock = 8'(step); req_valid = 1;
    @(posedge clk); #1;
    e.data = use_exp ? exp : model(idx, md, cm, blk, a, b, fader, actr, step);
    e.acc  = cyc;
    e.nm   = nm;
    q.push_back(e);
    // scramble inputs so a design that fails to capture them shows up
    req_valid = 0;
    req_index = 8'($urandom); mode = 2'($urandom); colmode = 3'($urandom);
    blocksize = 8'($urandom); usera = DW'($urandom); userb = DW'($urandom);
    masterfader = 8'($urandom); animationcounter = 8'($urandom); stepclock = 8'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 400) begin @(negedge clk); n++; end
    if (q.size() != 0) begin
      chk("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  initial begin
    int idx, actr;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_pix_valid", 32'(pix_valid), 32'd0);
    chk("reset_pix_data",  32'(pix_data),  32'd0);
    rst_n = 1;

    send(3, 0, 0, 0, 24'h0080FF, 24'h0, 255, 0, 0, "solid", 1, 24'h007FFE);
    drain();
    send(0, 0, 2, 0, 24'h000000, 24'hFFFFFF, 255, 0, 0, "gradient", 1, 24'hFDFDFD);
    send(0, 1, 0, 0, 24'hFFFFFF, 24'h0, 255, 0, 0, "chase_idx0", 1, 24'hFDFDFD);
    send(5, 1, 0, 0, 24'hFFFFFF, 24'h0, 255, 0, 0, "chase_idx5", 1, 24'h000000);
    send(5, 2, 0, 0, 24'hFFFFFF, 24'h0, 255, 0, 0, "inv_chase_idx5", 1, 24'hFDFDFD);
    send(0, 0, 5, 0, 24'h0, 24'h0, 255, 0, 0, "rainbow", 1, 24'hA9A900);
    drain();

    // stall the consumer; a second request must be ignored during OUT
    force_low = 1;
    send(2, 0, 0, 0, 24'h123456, 24'h0, 255, 0, 0, "stall", 0, 24'h0);
    begin
      int n = 0;
      while (!pix_valid && n < 100) begin @(negedge clk); n++; end
      chk("stall_valid_seen", 32'(pix_valid), 32'd1);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_valid = 1; req_index = 8'h22;
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 0;
    force_low = 0;
    drain();
    repeat (25) @(negedge clk);
    chk("no_queued_request", 32'(pix_valid), 32'd0);

    // reset in the middle of a pixel: prior output is nonzero, must clear at once
    send(3, 0, 0, 0, 24'h0080FF, 24'h0, 255, 0, 0, "pre_abort", 1, 24'h007FFE);
    drain();
    send(1, 0, 1, 0, 24'h0, 24'h445566, 255, 0, 0, "aborted", 0, 24'h0);
    repeat (6) @(posedge clk);
    #1 rst_n = 0;
    q.delete();
    #1;
    chk("abort_pix_valid", 32'(pix_valid), 32'd0);
    chk("abort_pix_data",  32'(pix_data),  32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1;
    repeat (25) @(negedge clk);
    chk("no_valid_after_abort", 32'(pix_valid), 32'd0);

    rand_ready = 1;
    for (int i = 0; i < 40; i++) begin
      actr = $urandom_range(0, 255);
      idx  = (i % 2 == 0) ? $urandom_range(0, 255) : ((actr * (NL + 5)) >> 8) + $urandom_range(0, 4);
      send(idx % 256, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 255),
           DW'($urandom), DW'($urandom), $urandom_range(0, 255), actr,
           $urandom_range(0, 255), "random", 0, 24'h0);
    end
    drain();
    rand_ready = 0;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
